vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_timer.sv | 29 ++
 rtl/vend_sequencer.sv | 117 +++++++++++
 tb/tb_vend_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the bottle vending sequencer.
// Coin encodings, coin values, FSM state enum and credit width.
package vend_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [1:0] COIN_INV = 2'b00;
    localparam logic [1:0] COIN_R1  = 2'b01;
    localparam logic [1:0] COIN_R2  = 2'b10;
    localparam logic [1:0] COIN_R5  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE
    } state_t;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W-1:0] v;
        case (code)
            COIN_R1: v = 4'd1;
            COIN_R2: v = 4'd2;
            COIN_R5: v = 4'd5;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Dispense acknowledge watchdog: counts cycles while enabled,
// flags expiry on the last allowed cycle, held at zero by clear.
module vend_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    assign expired = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Bottle vending sequencer: coin credit, dispense handshake with
// watchdog, Rs1 change/refund ejection and sticky fault lockout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ready,
    output logic                coin_en,
    output logic                coin_rej,
    output logic                disp_req,
    output logic                chg_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [7:0]          vend_count,
    output logic                fault
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state;
    state_t              state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] sum;
    logic [7:0]          count_n;
    logic                fault_n;
    logic                coin_ok;
    logic                expired;

    assign coin_en = ((state == IDLE) || (state == COLLECT)) && !fault;
    assign coin_ok = coin_valid && coin_en && (coin_code != COIN_INV);
    assign sum     = credit + coin_value(coin_code);

    vend_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != DISPENSE),
        .enable  (state == DISPENSE),
        .expired (expired)
    );

    always_comb begin
        state_n   = state;
        credit_n  = credit;
        count_n   = vend_count;
        fault_n   = fault;
        chg_pulse = 1'b0;
        unique case (state)
            IDLE: begin
                if (coin_ok) begin
                    credit_n = sum;
                    state_n  = (sum >= PRICE_C) ? DISPENSE : COLLECT;
                end
            end
            COLLECT: begin
                if (coin_ok) begin
                    credit_n = sum;
                end
                // Cancel refunds everything, including a same-cycle coin.
                if (cancel) begin
                    state_n = CHANGE;
                end else if (coin_ok && (sum >= PRICE_C)) begin
                    state_n = DISPENSE;
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_n = credit - PRICE_C;
                    count_n  = vend_count + 8'd1;
                    state_n  = (credit_n != '0) ? CHANGE : IDLE;
                end else if (expired) begin
                    fault_n = 1'b1;
                    state_n = CHANGE;
                end
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_n = IDLE;
                end else if (chg_ready) begin
                    chg_pulse = 1'b1;
                    credit_n  = credit - 1'b1;
                    if (credit == 4'd1) begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            credit     <= '0;
            vend_count <= '0;
            fault      <= 1'b0;
            coin_rej   <= 1'b0;
            disp_req   <= 1'b0;
        end else begin
            state      <= state_n;
            credit     <= credit_n;
            vend_count <= count_n;
            fault      <= fault_n;
            coin_rej   <= coin_valid && !coin_ok;
            disp_req   <= (state_n == DISPENSE);
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (PRICE 5, TIMEOUT 15).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ready;
    logic       coin_en;
    logic       coin_rej;
    logic       disp_req;
    logic       chg_pulse;
    logic [3:0] credit;
    logic [7:0] vend_count;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int pulses;
    int exp_cnt;

    vend_sequencer #(
        .PRICE   (5),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_code  (coin_code),
        .cancel     (cancel),
        .disp_ack   (disp_ack),
        .chg_ready  (chg_ready),
        .coin_en    (coin_en),
        .coin_rej   (coin_rej),
        .disp_req   (disp_req),
        .chg_pulse  (chg_pulse),
        .credit     (credit),
        .vend_count (vend_count),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
        coin_code  = 2'b00;
    endtask

    task automatic count_pulses(input int n);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (chg_pulse) pulses++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_code  = 2'b00;
        cancel     = 1'b0;
        disp_ack   = 1'b0;
        chg_ready  = 1'b0;
        exp_cnt    = 0;
        tick();
        tick();
        chk("rst_coin_en", coin_en, 1);
        chk("rst_coin_rej", coin_rej, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_chg_pulse", chg_pulse, 0);
        chk("rst_credit", credit, 0);
        chk("rst_count", vend_count, 0);
        chk("rst_fault", fault, 0);
        rst = 1'b0;
        tick();

        // Rs5 from idle: immediate dispense, ack after 3 cycles.
        coin(2'b11);
        chk("r5_disp_req", disp_req, 1);
        chk("r5_credit", credit, 5);
        chk("r5_coin_en", coin_en, 0);
        tick();
        tick();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        exp_cnt++;
        chk("r5_ack_credit", credit, 0);
        chk("r5_ack_count", vend_count, exp_cnt);
        chk("r5_ack_disp_req", disp_req, 0);
        chk("r5_ack_coin_en", coin_en, 1);
        chk("r5_no_change", chg_pulse, 0);

        // Ack outside DISPENSE is ignored.
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        chk("stray_ack_count", vend_count, exp_cnt);

        // Rs2 x3: dispense at 6, one Rs1 change, stall on chg_ready.
        coin(2'b10);
        chk("r2a_credit", credit, 2);
        chk("r2a_disp_req", disp_req, 0);
        coin(2'b10);
        chk("r2b_credit", credit, 4);
        coin(2'b10);
        chk("r2c_credit", credit, 6);
        chk("r2c_disp_req", disp_req, 1);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        exp_cnt++;
        chk("r2_ack_credit", credit, 1);
        chk("r2_ack_count", vend_count, exp_cnt);
        tick();
        chk("chg_stall_credit", credit, 1);
        chk("chg_stall_pulse", chg_pulse, 0);
        chg_ready = 1'b1;
        #1;
        chk("chg_mealy_pulse", chg_pulse, 1);
        tick();
        chg_ready = 1'b0;
        chk("chg_done_credit", credit, 0);
        chk("chg_done_coin_en", coin_en, 1);

        // Cancel in IDLE is ignored.
        cancel    = 1'b1;
        chg_ready = 1'b1;
        tick();
        #1;
        chk("idle_cancel_pulse", chg_pulse, 0);
        chk("idle_cancel_coin_en", coin_en, 1);
        cancel    = 1'b0;
        chg_ready = 1'b0;

        // Rs1, Rs2, cancel: three change pulses, no vend.
        coin(2'b01);
        coin(2'b10);
        chk("cancel_pre_credit", credit, 3);
        cancel    = 1'b1;
        chg_ready = 1'b1;
        tick();
        cancel = 1'b0;
        count_pulses(5);
        chg_ready = 1'b0;
        chk("cancel_pulses", pulses, 3);
        chk("cancel_count", vend_count, exp_cnt);
        chk("cancel_credit", credit, 0);

        // Coin and cancel together: total refunded even above price.
        coin(2'b10);
        coin_valid = 1'b1;
        coin_code  = 2'b11;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        chk("cc_credit", credit, 7);
        chk("cc_disp_req", disp_req, 0);
        chg_ready = 1'b1;
        count_pulses(9);
        chg_ready = 1'b0;
        chk("cc_pulses", pulses, 7);
        chk("cc_count", vend_count, exp_cnt);

        // Invalid code: reject next cycle, credit unchanged.
        coin(2'b00);
        chk("inv_rej", coin_rej, 1);
        chk("inv_credit", credit, 0);
        tick();
        chk("inv_rej_clear", coin_rej, 0);

        // Credit 4 + Rs5, no ack: timeout, refund 9, lockout.
        coin(2'b10);
        coin(2'b10);
        coin(2'b11);
        chk("to_credit", credit, 9);
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_disp_req", disp_req, 1);
        chk("to_pre_fault", fault, 0);
        tick();
        chk("to_fault", fault, 1);
        chk("to_disp_req", disp_req, 0);
        chk("to_credit_kept", credit, 9);
        chk("to_count", vend_count, exp_cnt);
        chg_ready = 1'b1;
        count_pulses(12);
        chg_ready = 1'b0;
        chk("to_pulses", pulses, 9);
        chk("to_end_credit", credit, 0);
        chk("to_lock_coin_en", coin_en, 0);
        coin(2'b01);
        chk("to_lock_rej", coin_rej, 1);
        chk("to_lock_credit", credit, 0);

        // Reset clears fault; ack on the expiry cycle wins.
        do_reset();
        exp_cnt = 0;
        chk("rst2_fault", fault, 0);
        chk("rst2_count", vend_count, 0);
        coin(2'b11);
        coin(2'b01);
        chk("disp_coin_rej", coin_rej, 1);
        chk("disp_coin_credit", credit, 5);
        for (int i = 0; i < 13; i++) tick();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        exp_cnt++;
        chk("race_fault", fault, 0);
        chk("race_count", vend_count, exp_cnt);
        chk("race_credit", credit, 0);
        chk("race_coin_en", coin_en, 1);

        // Reset mid-CHANGE with credit 3.
        coin(2'b01);
        coin(2'b10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("rchg_credit", credit, 3);
        chg_ready = 1'b1;
        #1;
        chk("rchg_pulse_pre", chg_pulse, 1);
        rst = 1'b1;
        #1;
        chk("rchg_pulse", chg_pulse, 0);
        chk("rchg_credit0", credit, 0);
        tick();
        rst       = 1'b0;
        chg_ready = 1'b0;
        tick();
        chk("rchg_after_credit", credit, 0);
        chk("rchg_after_count", vend_count, 0);
        exp_cnt = 0;

        // vend_count wraps 255 -> 0.
        for (int i = 0; i < 256; i++) begin
            coin(2'b11);
            disp_ack = 1'b1;
            tick();
            disp_ack = 1'b0;
            exp_cnt = (exp_cnt + 1) % 256;
            if (i == 254) chk("wrap_255", vend_count, 255);
        end
        chk("wrap_0", vend_count, exp_cnt);
        chk("wrap_credit", credit, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
